// File: rtl/fetch_ref_chroma_loader_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ref_chroma_loader_pkg
//   Shared constants, FSM encoding and the window-height helper for the chroma
//   reference window loader.
//   Configuration macro recognised by the loader: FETCH_REF_CHROMA_CHK_EN.
// -----------------------------------------------------------------------------
package fetch_ref_chroma_loader_pkg;

   // Encoder-wide geometry.
   localparam int PIXEL_WIDTH = 8;
   localparam int PIC_Y_WIDTH = 8;

   // Fetch beat: 8 U and 8 V pixels, interleaved UVUV, U0 in the MSBs.
   localparam int FETCH_CH_BEAT_W    = 128;
   localparam int FETCH_CH_BEAT_PIX  = 8;
   localparam int FETCH_CH_HALF_W    = FETCH_CH_BEAT_PIX * PIXEL_WIDTH;

   // Window geometry.
   localparam int FETCH_CH_ROW_BEATS = 6;
   localparam int FETCH_CH_ROWS_FULL = 48;
   localparam int FETCH_CH_ROWS_EDGE = 40;
   localparam int FETCH_CH_ROW_PIX   = FETCH_CH_ROW_BEATS * FETCH_CH_BEAT_PIX;
   localparam int FETCH_CH_ROW_W     = FETCH_CH_ROW_PIX * PIXEL_WIDTH;
   localparam int FETCH_CH_LOAD_W    = 2 * FETCH_CH_ROW_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } fetch_ch_state_e;

   // The first and last LCU rows of the picture have no neighbour on one side,
   // so their reference window is shorter.
   function automatic logic [5:0] rows_for_lcu(input logic [PIC_Y_WIDTH-1:0] cur_y,
                                               input logic [PIC_Y_WIDTH-1:0] total_y);
      if (cur_y == '0 || cur_y == total_y)
         return 6'(FETCH_CH_ROWS_EDGE);
      return 6'(FETCH_CH_ROWS_FULL);
   endfunction

endpackage

// File: rtl/fetch_ref_chroma_loader_if.sv
// -----------------------------------------------------------------------------
// fetch_ref_chroma_loader_if
//   Bundles the external-memory fetch channel (beat in, ready out) and the
//   row-write channel towards the window buffer.
//   ext_data/ext_valid/ext_ready : fetch beats, accepted on valid & ready
//   load_valid/load_addr/load_data: one-cycle row write strobe, row index, {U,V}
//   load_done                    : one-cycle pulse after the last row write
//   Modports: master = fetch side / buffer side (testbench), slave = loader.
// -----------------------------------------------------------------------------
interface fetch_ref_chroma_loader_if;
   import fetch_ref_chroma_loader_pkg::*;

   logic [FETCH_CH_BEAT_W-1:0] ext_data;
   logic                       ext_valid;
   logic                       ext_ready;
   logic                       load_valid;
   logic [5:0]                 load_addr;
   logic [FETCH_CH_LOAD_W-1:0] load_data;
   logic                       load_done;

   modport master (
      output ext_data, ext_valid,
      input  ext_ready, load_valid, load_addr, load_data, load_done
   );

   modport slave (
      input  ext_data, ext_valid,
      output ext_ready, load_valid, load_addr, load_data, load_done
   );

endinterface

// File: rtl/fetch_ref_chroma_loader_uv_deinterleave.sv
// -----------------------------------------------------------------------------
// fetch_uv_deinterleave
//   Combinational split of one interleaved UVUV beat into its 8 U and 8 V
//   pixels, pixel 0 kept in the MSBs of each output.
//   i_beat  : 128-bit beat, [127:120]=U0, [119:112]=V0, ..., [7:0]=V7
//   o_u_pix : U0..U7, 64 bits
//   o_v_pix : V0..V7, 64 bits
// -----------------------------------------------------------------------------
module fetch_uv_deinterleave
   import fetch_ref_chroma_loader_pkg::*;
(
   input  logic [FETCH_CH_BEAT_W-1:0] i_beat,
   output logic [FETCH_CH_HALF_W-1:0] o_u_pix,
   output logic [FETCH_CH_HALF_W-1:0] o_v_pix
);

   // NOTE: every output of a combinational block is given a default first so
   // no path through the block leaves it unassigned (no latch is inferred).
   always_comb begin
      o_u_pix = '0;
      o_v_pix = '0;
      for (int i = 0; i < FETCH_CH_BEAT_PIX; i++) begin
         o_u_pix[FETCH_CH_HALF_W-1-PIXEL_WIDTH*i -: PIXEL_WIDTH] =
            i_beat[FETCH_CH_BEAT_W-1-2*PIXEL_WIDTH*i -: PIXEL_WIDTH];
         o_v_pix[FETCH_CH_HALF_W-1-PIXEL_WIDTH*i -: PIXEL_WIDTH] =
            i_beat[FETCH_CH_BEAT_W-1-PIXEL_WIDTH-2*PIXEL_WIDTH*i -: PIXEL_WIDTH];
      end
   end

endmodule

// File: rtl/fetch_ref_chroma_loader.sv
// -----------------------------------------------------------------------------
// fetch_ref_chroma_loader
//   Feeds the chroma reference window buffer: packs 6 interleaved UVUV beats
//   into one 48-pixel U row and one 48-pixel V row, writes one row per 6
//   accepted beats and pulses done one cycle after the last row write.
//   Window height is 48 rows, or 40 on the first/last LCU row of the picture.
//   Ports:
//     clk, rstn         : clock, asynchronous active-low reset
//     sysif_start_i     : LCU-level start, aborts any load in progress
//     sysif_total_y_i   : last LCU row index of the picture
//     load_start_i      : begin loading the window for cur_y_i
//     cur_y_i           : LCU row index, sampled with load_start_i
//     ext_if (slave)    : fetch beats in, row writes and done out
//     busy_o            : high while loading
//     err_o             : only with FETCH_REF_CHROMA_CHK_EN; sticky protocol
//                         error (beat outside LOAD, start while busy), cleared
//                         by sysif_start_i
// -----------------------------------------------------------------------------
module fetch_ref_chroma_loader
   import fetch_ref_chroma_loader_pkg::*;
(
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   sysif_start_i,
   input  logic [PIC_Y_WIDTH-1:0] sysif_total_y_i,
   input  logic                   load_start_i,
   input  logic [PIC_Y_WIDTH-1:0] cur_y_i,
   fetch_ref_chroma_loader_if.slave ext_if,
   output logic                   busy_o
`ifdef FETCH_REF_CHROMA_CHK_EN
   ,
   output logic                   err_o
`endif
);

   fetch_ch_state_e r_state, w_state_nxt;

   logic [2:0]                 r_beat_cnt;
   logic [5:0]                 r_row_cnt;
   logic [5:0]                 r_rows_last;
   logic [FETCH_CH_ROW_W-1:0]  r_u_sreg, r_v_sreg;
   logic [FETCH_CH_ROW_W-1:0]  w_u_shift, w_v_shift;
   logic [FETCH_CH_HALF_W-1:0] w_u_pix, w_v_pix;
   logic                       w_ready, w_accept, w_row_done, w_last_row;
   logic                       r_load_valid, r_load_done;
   logic [5:0]                 r_load_addr;
   logic [FETCH_CH_LOAD_W-1:0] r_load_data;

   fetch_uv_deinterleave u_deinterleave (
      .i_beat  (ext_if.ext_data),
      .o_u_pix (w_u_pix),
      .o_v_pix (w_v_pix)
   );

   // Abort has priority over everything, including a beat in the same cycle.
   assign w_accept   = ext_if.ext_valid & w_ready & ~sysif_start_i;
   assign w_row_done = w_accept & (r_beat_cnt == 3'(FETCH_CH_ROW_BEATS - 1));
   assign w_last_row = w_row_done & (r_row_cnt == r_rows_last);

   assign w_u_shift = {r_u_sreg[FETCH_CH_ROW_W-FETCH_CH_HALF_W-1:0], w_u_pix};
   assign w_v_shift = {r_v_sreg[FETCH_CH_ROW_W-FETCH_CH_HALF_W-1:0], w_v_pix};

   // NOTE: state and datapath registers use non-blocking assignments so every
   // flop samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      busy_o      = 1'b0;
      case (r_state)
         IDLE: if (load_start_i && !sysif_start_i) w_state_nxt = LOAD;
         LOAD: begin
            w_ready = 1'b1;
            busy_o  = 1'b1;
            if (sysif_start_i)   w_state_nxt = IDLE;
            else if (w_last_row) w_state_nxt = DONE;
         end
         // The last row write is visible during DONE; done follows it.
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign ext_if.ext_ready = w_ready;

   // NOTE: the shift registers are ordinary flops, not a memory array, so
   // they are reset with everything else; a partial row never survives reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_beat_cnt   <= '0;
         r_row_cnt    <= '0;
         r_rows_last  <= '0;
         r_u_sreg     <= '0;
         r_v_sreg     <= '0;
         r_load_valid <= 1'b0;
         r_load_addr  <= '0;
         r_load_data  <= '0;
         r_load_done  <= 1'b0;
      end else begin
         r_load_valid <= w_row_done;
         r_load_done  <= (r_state == DONE) && !sysif_start_i;

         if (r_state == IDLE && load_start_i)
            r_rows_last <= rows_for_lcu(cur_y_i, sysif_total_y_i) - 6'd1;

         if (r_state != LOAD || sysif_start_i) begin
            r_beat_cnt <= '0;
            r_row_cnt  <= '0;
         end else if (w_accept) begin
            r_beat_cnt <= w_row_done ? 3'd0 : r_beat_cnt + 3'd1;
            if (w_row_done) r_row_cnt <= r_row_cnt + 6'd1;
         end

         if (w_accept) begin
            r_u_sreg <= w_u_shift;
            r_v_sreg <= w_v_shift;
         end

         // Output registers change only on row completion, so a beat taken
         // during the write cycle cannot disturb the data being written.
         if (w_row_done) begin
            r_load_addr <= r_row_cnt;
            r_load_data <= {w_u_shift, w_v_shift};
         end
      end
   end

   assign ext_if.load_valid = r_load_valid;
   assign ext_if.load_addr  = r_load_addr;
   assign ext_if.load_data  = r_load_data;
   assign ext_if.load_done  = r_load_done;

`ifdef FETCH_REF_CHROMA_CHK_EN
   logic r_err;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         r_err <= 1'b0;
      else if (sysif_start_i)
         r_err <= 1'b0;
      else if ((ext_if.ext_valid && r_state != LOAD) || (load_start_i && r_state == LOAD))
         r_err <= 1'b1;
   end

   assign err_o = r_err;
`endif

endmodule
